// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU/memory sequencer: FSM state encoding,
// bus widths, and the code-address helper used by the fetch path.
package cpu_mem_pkg;

    localparam int INSTR_W = 26;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FWAIT,
        STEP,
        EXEC,
        DRD,
        DCAP,
        DWR
    } seqState_t;

    // Byte address of byte k of instruction ip; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] codeAddr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] ip,
        input logic [1:0]        k
    );
        return base + {ip[ADDR_W-3:0], 2'b00} + {{(ADDR_W-2){1'b0}}, k};
    endfunction

endpackage

// File: rtl/cpu_fetch_buffer.sv
// Instruction byte assembly register and, when SEQ_IBUF_EN is defined,
// a one-entry instruction buffer (valid bit + IP tag) with write snooping.
module cpu_fetch_buffer
    import cpu_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CODE_BASE = 16'h8000
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               shiftEn,
    input  logic               loadEn,
    input  logic [DATA_W-1:0]  rdData,
    input  logic [ADDR_W-1:0]  fetchIp,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  wrAddr,
    output logic [INSTR_W-1:0] instruction,
    output logic               hit
);

    localparam int HOLD_W = INSTR_W - DATA_W;

    // Holds byte0[1:0], byte1, byte2; byte0[7:2] falls off the top while shifting.
    logic [HOLD_W-1:0] holdReg;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            holdReg     <= '0;
            instruction <= '0;
        end else begin
            if (shiftEn) holdReg <= {holdReg[HOLD_W-DATA_W-1:0], rdData};
            if (loadEn)  instruction <= {holdReg, rdData};
        end
    end

`ifdef SEQ_IBUF_EN
    logic              tagValid;
    logic [ADDR_W-1:0] tagIp;
    logic [ADDR_W-1:0] wrOffset;

    assign wrOffset = wrAddr - codeAddr(CODE_BASE, tagIp, 2'd0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tagValid <= 1'b0;
            tagIp    <= '0;
        end else if (loadEn) begin
            tagValid <= 1'b1;
            tagIp    <= fetchIp;
        end else if (wrEn && (wrOffset[ADDR_W-1:2] == '0)) begin
            tagValid <= 1'b0;
        end
    end

    assign hit = tagValid && (tagIp == fetchIp);
`else
    logic unusedIbufInputs;
    assign unusedIbufInputs = ^{fetchIp, wrEn, wrAddr};
    assign hit = 1'b0;
`endif

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Sequences instruction fetch, CPU step and data read/write over one shared
// byte memory. Optional instruction buffer enabled by macro SEQ_IBUF_EN.
module cpu_mem_sequencer
    import cpu_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CODE_BASE = 16'h8000
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic [ADDR_W-1:0]  instructionPointer,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpuStep,
    input  logic               readValueIn,
    input  logic [ADDR_W-1:0]  addressIn,
    output logic [DATA_W-1:0]  valueIn,
    input  logic               writeValueOut,
    input  logic [ADDR_W-1:0]  addressOut,
    input  logic [DATA_W-1:0]  valueOut,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [DATA_W-1:0]  memWrData,
    output logic               memRe,
    output logic               memWe,
    input  logic [DATA_W-1:0]  memRdData,
    output logic               busy
);

    seqState_t         state, nextState;
    logic [1:0]        byteCnt;
    logic [ADDR_W-1:0] fetchIp;
    logic [ADDR_W-1:0] rdAddrLat, wrAddrLat;
    logic [DATA_W-1:0] wrDataLat;
    logic              wrPending;
    logic              hit;
    logic              fetchHit;

    assign fetchHit = hit && (byteCnt == 2'd0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  nextState = FETCH;
            FETCH: begin
                if (fetchHit)               nextState = STEP;
                else if (byteCnt == 2'd3)   nextState = FWAIT;
            end
            FWAIT: nextState = STEP;
            STEP:  nextState = EXEC;
            EXEC: begin
                if (readValueIn)        nextState = DRD;
                else if (writeValueOut) nextState = DWR;
                else                    nextState = FETCH;
            end
            DRD:   nextState = DCAP;
            DCAP:  nextState = wrPending ? DWR : FETCH;
            DWR:   nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: IP is captured on the edge entering FETCH, requests in EXEC.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            byteCnt   <= '0;
            fetchIp   <= '0;
            rdAddrLat <= '0;
            wrAddrLat <= '0;
            wrDataLat <= '0;
            wrPending <= 1'b0;
            valueIn   <= '0;
        end else begin
            byteCnt <= (state == FETCH) ? byteCnt + 2'd1 : 2'd0;
            if (nextState == FETCH && state != FETCH) fetchIp <= instructionPointer;
            if (state == EXEC) begin
                rdAddrLat <= addressIn;
                wrAddrLat <= addressOut;
                wrDataLat <= valueOut;
                wrPending <= writeValueOut;
            end
            if (state == DCAP) valueIn <= memRdData;
        end
    end

    always_comb begin
        memAddr   = '0;
        memWrData = '0;
        memRe     = 1'b0;
        memWe     = 1'b0;
        cpuStep   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            FETCH: begin
                memAddr = codeAddr(CODE_BASE, fetchIp, byteCnt);
                memRe   = !fetchHit;
            end
            STEP:  cpuStep = 1'b1;
            DRD: begin
                memAddr = rdAddrLat;
                memRe   = 1'b1;
            end
            DWR: begin
                memAddr   = wrAddrLat;
                memWrData = wrDataLat;
                memWe     = 1'b1;
            end
            default: ;
        endcase
    end

    cpu_fetch_buffer #(
        .CODE_BASE(CODE_BASE)
    ) fetchBuffer (
        .clock      (clock),
        .resetN     (resetN),
        .shiftEn    ((state == FETCH) && (byteCnt != 2'd0)),
        .loadEn     (state == FWAIT),
        .rdData     (memRdData),
        .fetchIp    (fetchIp),
        .wrEn       (state == DWR),
        .wrAddr     (wrAddrLat),
        .instruction(instruction),
        .hit        (hit)
    );

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Self-checking bench for cpu_mem_sequencer: transaction-level reference model
// of fetch/step/access timing, directed cases plus randomized instructions.
module tb_cpu_mem_sequencer;

    localparam logic [15:0] TB_BASE   = 16'h8000;
    localparam logic [15:0] WRAP_BASE = 16'hFFFC;
`ifdef SEQ_IBUF_EN
    localparam bit IBUF_EN = 1'b1;
`else
    localparam bit IBUF_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic [15:0] instructionPointer = '0;
    logic [25:0] instruction;
    logic        cpuStep;
    logic        readValueIn = 1'b0;
    logic [15:0] addressIn = '0;
    logic [7:0]  valueIn;
    logic        writeValueOut = 1'b0;
    logic [15:0] addressOut = '0;
    logic [7:0]  valueOut = '0;
    logic [15:0] memAddr;
    logic [7:0]  memWrData;
    logic        memRe, memWe;
    logic [7:0]  memRdData = '0;
    logic        busy;

    // Second instance: code base near the top of memory to exercise wrap.
    logic [15:0] wIp = 16'h0001;
    logic        wReadValueIn = 1'b0, wWriteValueOut = 1'b0;
    logic [15:0] wAddressIn = '0, wAddressOut = '0;
    logic [7:0]  wValueOut = '0;
    logic [25:0] wInstruction;
    logic        wCpuStep, wMemRe, wMemWe, wBusy;
    logic [7:0]  wValueIn, wMemWrData;
    logic [15:0] wMemAddr;
    logic [7:0]  wMemRdData = '0;

    logic [7:0]  mem    [0:65535];
    logic [7:0]  refMem [0:65535];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] curIp;
    logic [25:0] expInstr;
    logic [7:0]  expValueIn;
    bit          refValid;
    logic [15:0] refTag;

    always #5 clock = ~clock;

    cpu_mem_sequencer #(.CODE_BASE(TB_BASE)) dut (
        .clock(clock), .resetN(resetN), .instructionPointer(instructionPointer),
        .instruction(instruction), .cpuStep(cpuStep),
        .readValueIn(readValueIn), .addressIn(addressIn), .valueIn(valueIn),
        .writeValueOut(writeValueOut), .addressOut(addressOut), .valueOut(valueOut),
        .memAddr(memAddr), .memWrData(memWrData), .memRe(memRe), .memWe(memWe),
        .memRdData(memRdData), .busy(busy)
    );

    cpu_mem_sequencer #(.CODE_BASE(WRAP_BASE)) dutWrap (
        .clock(clock), .resetN(resetN), .instructionPointer(wIp),
        .instruction(wInstruction), .cpuStep(wCpuStep),
        .readValueIn(wReadValueIn), .addressIn(wAddressIn), .valueIn(wValueIn),
        .writeValueOut(wWriteValueOut), .addressOut(wAddressOut), .valueOut(wValueOut),
        .memAddr(wMemAddr), .memWrData(wMemWrData), .memRe(wMemRe), .memWe(wMemWe),
        .memRdData(wMemRdData), .busy(wBusy)
    );

    // Memory responders: read data valid the cycle after memRe.
    always @(posedge clock) begin
        if (memRe) memRdData <= mem[memAddr];
        if (memWe) mem[memAddr] <= memWrData;
    end

    always @(posedge clock) begin
        if (wMemRe) wMemRdData <= mem[wMemAddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetOutputs();
        check("rstInstr",   32'(instruction), 0);
        check("rstStep",    32'(cpuStep), 0);
        check("rstValueIn", 32'(valueIn), 0);
        check("rstAddr",    32'(memAddr), 0);
        check("rstWrData",  32'(memWrData), 0);
        check("rstRe",      32'(memRe), 0);
        check("rstWe",      32'(memWe), 0);
        check("rstBusy",    32'(busy), 0);
        check("rstWrapOut", 32'({wInstruction, wCpuStep, wValueIn}), 0);
        check("rstWrapMem", 32'({wMemAddr, wMemWrData, wMemRe, wMemWe, wBusy}), 0);
    endtask

    // Asserts reset at the current time, checks outputs, releases, and
    // returns at the negedge of the first FETCH cycle.
    task automatic doReset();
        resetN = 1'b0;
        #1;
        checkResetOutputs();
        expInstr   = '0;
        expValueIn = '0;
        refValid   = 1'b0;
        repeat (2) @(negedge clock);
        check("idleBusy", 32'(busy), 0);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic [15:0] fetchAddr(input logic [15:0] base, input logic [15:0] ip, input int k);
        logic [15:0] a;
        a = 16'(base + 4 * ip + k);
        return a;
    endfunction

    function automatic bit inTaggedWord(input logic [15:0] a);
        for (int k = 0; k < 4; k++)
            if (a == fetchAddr(TB_BASE, refTag, k)) return 1'b1;
        return 1'b0;
    endfunction

    // One instruction, entered at the negedge of its first FETCH cycle.
    task automatic runInstr(input logic [15:0] nextIp, input bit rd, input logic [15:0] ra,
                            input bit wr, input logic [15:0] wa, input logic [7:0] wd,
                            input bit chkWrap);
        bit hitExp;
        hitExp = IBUF_EN && refValid && (refTag == curIp);
        check("valueInHold", 32'(valueIn), 32'(expValueIn));
        check("fetchBusy", 32'(busy), 1);
        if (hitExp) begin
            check("hitNoRe", 32'(memRe), 0);
            @(negedge clock);
        end else begin
            for (int k = 0; k < 4; k++) begin
                check("fetchRe", 32'(memRe), 1);
                check("fetchAddr", 32'(memAddr), 32'(fetchAddr(TB_BASE, curIp, k)));
                check("fetchNoWe", 32'(memWe), 0);
                if (chkWrap) begin
                    check("wrapRe", 32'(wMemRe), 1);
                    check("wrapAddr", 32'(wMemAddr), 32'(fetchAddr(WRAP_BASE, 16'h0001, k)));
                end
                @(negedge clock);
            end
            check("fwaitRe", 32'(memRe), 0);
            check("fwaitStep", 32'(cpuStep), 0);
            check("noPartial", 32'(instruction), 32'(expInstr));
            expInstr = {refMem[fetchAddr(TB_BASE, curIp, 0)][1:0], refMem[fetchAddr(TB_BASE, curIp, 1)],
                        refMem[fetchAddr(TB_BASE, curIp, 2)], refMem[fetchAddr(TB_BASE, curIp, 3)]};
            if (IBUF_EN) begin
                refValid = 1'b1;
                refTag   = curIp;
            end
            @(negedge clock);
        end
        check("cpuStep", 32'(cpuStep), 1);
        check("instr", 32'(instruction), 32'(expInstr));
        check("stepRe", 32'(memRe), 0);
        instructionPointer = nextIp;
        readValueIn   = rd;
        addressIn     = ra;
        writeValueOut = wr;
        addressOut    = wa;
        valueOut      = wd;
        @(negedge clock);
        check("execStep", 32'(cpuStep), 0);
        check("execRe", 32'(memRe), 0);
        check("execWe", 32'(memWe), 0);
        check("execBusy", 32'(busy), 1);
        @(negedge clock);
        readValueIn   = 1'b0;
        writeValueOut = 1'b0;
        addressIn     = 16'($urandom);
        addressOut    = 16'($urandom);
        valueOut      = 8'($urandom);
        if (rd) begin
            check("drdRe", 32'(memRe), 1);
            check("drdWe", 32'(memWe), 0);
            check("drdAddr", 32'(memAddr), 32'(ra));
            @(negedge clock);
            check("dcapRe", 32'(memRe), 0);
            check("dcapWe", 32'(memWe), 0);
            check("dcapBusy", 32'(busy), 1);
            expValueIn = refMem[ra];
            @(negedge clock);
        end
        if (wr) begin
            check("dwrWe", 32'(memWe), 1);
            check("dwrRe", 32'(memRe), 0);
            check("dwrAddr", 32'(memAddr), 32'(wa));
            check("dwrData", 32'(memWrData), 32'(wd));
            refMem[wa] = wd;
            if (IBUF_EN && refValid && inTaggedWord(wa)) refValid = 1'b0;
            @(negedge clock);
        end
        curIp = nextIp;
    endtask

    initial begin
        logic [15:0] nIp, ra, wa;
        bit          rd, wr;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 8'($urandom);
            refMem[i] = mem[i];
        end
        for (int k = 0; k < 8; k++) begin
            logic [63:0] codeBytes;
            codeBytes = 64'h00400000_FF40A001;
            mem[16'h8000 + k]    = codeBytes[63 - 8*k -: 8];
            refMem[16'h8000 + k] = mem[16'h8000 + k];
        end
        mem[16'h0010] = 8'h5A;
        refMem[16'h0010] = 8'h5A;

        curIp = 16'h0000;
        instructionPointer = curIp;
        #2;
        doReset();

        // IP 0, then IP 1 with byte0[7:2] dropped, then read, then read+write.
        runInstr(16'h0001, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b1);
        check("word0", 32'(instruction), 32'h0400000);
        runInstr(16'h0002, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0);
        check("word1", 32'(instruction), 32'h340A001);
        runInstr(16'h0003, 1'b1, 16'h0010, 1'b0, 16'h0, 8'h0, 1'b0);
        check("read5A", 32'(valueIn), 32'h5A);
        runInstr(16'h0004, 1'b1, 16'h0020, 1'b1, 16'h0030, 8'hC3, 1'b0);
        check("memC3", 32'(mem[16'h0030]), 32'hC3);

        for (int n = 0; n < 24; n++) begin
            nIp = (n == 23) ? 16'h1234 : 16'($urandom_range(0, 16'h0FFF));
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            ra  = 16'($urandom);
            wa  = 16'($urandom);
            runInstr(nIp, rd, ra, wr, wa, 8'($urandom), 1'b0);
        end

        // Abort during the third fetch byte, then restart from FETCH.
        for (int k = 0; k < 3; k++) begin
            check("abortRe", 32'(memRe), 1);
            check("abortAddr", 32'(memAddr), 32'(fetchAddr(TB_BASE, curIp, k)));
            if (k < 2) @(negedge clock);
        end
        doReset();
        runInstr(16'h0005, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b1);

        // IP held at 5: buffer hit when enabled, code write forces a refetch.
        runInstr(16'h0005, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0);
        runInstr(16'h0005, 1'b0, 16'h0, 1'b1, 16'(TB_BASE + 16'h0015), 8'h7E, 1'b0);
        runInstr(16'h0005, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0);
        runInstr(16'h0006, 1'b1, 16'(TB_BASE + 16'h0015), 1'b0, 16'h0, 8'h0, 1'b0);
        runInstr(16'h0006, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
